// File: rtl/sindoku_checker.sv
// SINdoku full-grid checker: scans all N x N cells over a shared synchronous read port,
// classifies each cell as correct, empty or wrong, and reports counts, verdict and first bad cell.
module sindoku_checker #(
  parameter int CELL_W = 4,
  parameter int N      = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Ack,
  output logic              Rd_Req,
  output logic [3:0]        Rd_Row,
  output logic [3:0]        Rd_Col,
  input  logic [CELL_W-1:0] Rd_Data,
  input  logic [CELL_W-1:0] Sol_Data,
  output logic              Correct,
  output logic [6:0]        Empty_Count,
  output logic [6:0]        Wrong_Count,
  output logic              First_Valid,
  output logic [3:0]        First_Row,
  output logic [3:0]        First_Col,
  output logic              q_Idle,
  output logic              q_Scan,
  output logic              q_Drain,
  output logic              q_Done
);

  localparam logic [3:0] LAST    = 4'(N - 1);
  localparam logic [6:0] MAX_CNT = 7'(N * N);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic       vld_p1;
  logic [3:0] row_p1, col_p1;
  logic       cell_empty_p1, cell_wrong_p1;
  logic [6:0] empty_nx, wrong_nx;
  logic       start_acc;

  function automatic logic [6:0] sat_inc(input logic [6:0] cnt, input logic en);
    if (en && (cnt < MAX_CNT)) return cnt + 7'd1;
    return cnt;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_SCAN;
      S_SCAN:  if ((Rd_Row == LAST) && (Rd_Col == LAST)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (Ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign q_Idle    = (state_q == S_IDLE);
  assign q_Scan    = (state_q == S_SCAN);
  assign q_Drain   = (state_q == S_DRAIN);
  assign q_Done    = (state_q == S_DONE);
  assign start_acc = q_Idle && Start;

  // Issue stage (p0): registered read strobe and row-major address walk
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Rd_Req <= 1'b0;
      Rd_Row <= '0;
      Rd_Col <= '0;
    end else begin
      Rd_Req <= (state_d == S_SCAN);
      if ((state_q == S_SCAN) && (state_d == S_SCAN)) begin
        if (Rd_Col == LAST) begin
          Rd_Col <= '0;
          Rd_Row <= Rd_Row + 4'd1;
        end else begin
          Rd_Col <= Rd_Col + 4'd1;
        end
      end else begin
        Rd_Row <= '0;
        Rd_Col <= '0;
      end
    end
  end

  // Compare stage (p1): address of the cell whose data is on Rd_Data/Sol_Data now
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) vld_p1 <= 1'b0;
    else       vld_p1 <= Rd_Req;
  end

  always_ff @(posedge Clk) begin
    row_p1 <= Rd_Row;
    col_p1 <= Rd_Col;
  end

  assign cell_empty_p1 = vld_p1 && (Rd_Data == '0);
  assign cell_wrong_p1 = vld_p1 && (Rd_Data != '0) && (Rd_Data != Sol_Data);
  assign empty_nx      = sat_inc(Empty_Count, cell_empty_p1);
  assign wrong_nx      = sat_inc(Wrong_Count, cell_wrong_p1);

  // Result registers: cleared by Reset or an accepted Start, otherwise held between scans
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Empty_Count <= '0;
      Wrong_Count <= '0;
      First_Valid <= 1'b0;
      First_Row   <= '0;
      First_Col   <= '0;
      Correct     <= 1'b0;
    end else if (start_acc) begin
      Empty_Count <= '0;
      Wrong_Count <= '0;
      First_Valid <= 1'b0;
      First_Row   <= '0;
      First_Col   <= '0;
      Correct     <= 1'b0;
    end else begin
      Empty_Count <= empty_nx;
      Wrong_Count <= wrong_nx;
      if ((cell_empty_p1 || cell_wrong_p1) && !First_Valid) begin
        First_Valid <= 1'b1;
        First_Row   <= row_p1;
        First_Col   <= col_p1;
      end
      // The DRAIN edge still folds in the last cell, so judge on the next-count values
      if (state_q == S_DRAIN)
        Correct <= (empty_nx == '0) && (wrong_nx == '0);
      else if (q_Done && Ack)
        Correct <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sindoku_checker.sv
// Bench for sindoku_checker: randomized grids scored by a cell-by-cell reference model,
// plus directed reset, Start/Ack interaction and boundary-cell scenarios.
module tb_sindoku_checker;

  logic       Clk = 1'b0;
  logic       Reset, Start, Ack;
  logic       Rd_Req;
  logic [3:0] Rd_Row, Rd_Col;
  logic [3:0] Rd_Data, Sol_Data;
  logic       Correct;
  logic [6:0] Empty_Count, Wrong_Count;
  logic       First_Valid;
  logic [3:0] First_Row, First_Col;
  logic       q_Idle, q_Scan, q_Drain, q_Done;

  int puz[81];
  int sol[81];
  int addr_log[$];
  int errors = 0;
  int checks = 0;

  int exp_empty, exp_wrong, exp_first;
  bit exp_fv, exp_correct;

  sindoku_checker #(.CELL_W(4), .N(9)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .Rd_Req(Rd_Req), .Rd_Row(Rd_Row), .Rd_Col(Rd_Col),
    .Rd_Data(Rd_Data), .Sol_Data(Sol_Data),
    .Correct(Correct), .Empty_Count(Empty_Count), .Wrong_Count(Wrong_Count),
    .First_Valid(First_Valid), .First_Row(First_Row), .First_Col(First_Col),
    .q_Idle(q_Idle), .q_Scan(q_Scan), .q_Drain(q_Drain), .q_Done(q_Done)
  );

  always #5 Clk = ~Clk;

  // Grid storage: answers one cycle after the strobe, garbage otherwise
  always @(posedge Clk) begin
    int idx;
    idx = int'(Rd_Row) * 9 + int'(Rd_Col);
    if (Rd_Req) begin
      Rd_Data  <= (idx < 81) ? 4'(puz[idx]) : 4'd0;
      Sol_Data <= (idx < 81) ? 4'(sol[idx]) : 4'd0;
      addr_log.push_back(idx);
    end else begin
      Rd_Data  <= 4'($urandom_range(0, 15));
      Sol_Data <= 4'($urandom_range(0, 15));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    exp_empty = 0;
    exp_wrong = 0;
    exp_fv    = 0;
    exp_first = 0;
    for (int i = 0; i < 81; i++) begin
      if (puz[i] == 0) exp_empty++;
      else if (puz[i] != sol[i]) exp_wrong++;
      if (!exp_fv && (puz[i] == 0 || puz[i] != sol[i])) begin
        exp_fv    = 1;
        exp_first = i;
      end
    end
    exp_correct = (exp_empty == 0) && (exp_wrong == 0);
  endtask

  task automatic run_check(input string name, input bit mid_start, input bit do_ack);
    int edges;
    int bad;
    model();
    addr_log.delete();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    edges = 0;
    while (!q_Done && edges < 200) begin
      @(posedge Clk);
      #1;
      edges++;
      Start = mid_start && (edges == 20);
    end
    Start = 1'b0;
    check({name, "_latency"}, edges, 82);
    check({name, "_addr_count"}, addr_log.size(), 81);
    bad = 0;
    foreach (addr_log[i]) if (addr_log[i] != i) bad++;
    check({name, "_addr_order"}, bad, 0);
    check({name, "_correct"}, Correct, exp_correct);
    check({name, "_empty"}, Empty_Count, exp_empty);
    check({name, "_wrong"}, Wrong_Count, exp_wrong);
    check({name, "_first_valid"}, First_Valid, exp_fv);
    if (exp_fv) begin
      check({name, "_first_row"}, First_Row, exp_first / 9);
      check({name, "_first_col"}, First_Col, exp_first % 9);
    end
    repeat (3) @(posedge Clk);
    #1;
    check({name, "_hold_done"}, q_Done, 1);
    check({name, "_hold_empty"}, Empty_Count, exp_empty);
    if (do_ack) begin
      @(negedge Clk);
      Ack = 1'b1;
      @(posedge Clk);
      #1 Ack = 1'b0;
      check({name, "_ack_idle"}, q_Idle, 1);
      check({name, "_ack_correct0"}, Correct, 0);
      check({name, "_ack_retain"}, Wrong_Count, exp_wrong);
    end
  endtask

  initial begin
    int n, j, r;
    Reset = 1'b1;
    Start = 1'b0;
    Ack   = 1'b0;
    for (int i = 0; i < 81; i++) begin
      sol[i] = $urandom_range(1, 9);
      puz[i] = sol[i];
    end
    #12;
    check("rst_idle", q_Idle, 1);
    check("rst_other_states", {q_Scan, q_Drain, q_Done}, 0);
    check("rst_rdreq", Rd_Req, 0);
    check("rst_addr", {Rd_Row, Rd_Col}, 0);
    check("rst_results", {Correct, Empty_Count, Wrong_Count, First_Valid, First_Row, First_Col}, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Ack in IDLE does nothing
    @(negedge Clk);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    check("ack_in_idle_state", q_Idle, 1);
    check("ack_in_idle_rdreq", Rd_Req, 0);

    run_check("solved", 0, 1);
    check("solved_spec_correct", Correct, 0);

    for (int i = 0; i < 81; i++) puz[i] = sol[i];
    puz[0] = 0;
    n = 1;
    while (n < 35) begin
      j = $urandom_range(1, 80);
      if (puz[j] != 0) begin
        puz[j] = 0;
        n++;
      end
    end
    run_check("blanks35", 0, 1);
    check("blanks35_spec_empty", Empty_Count, 35);

    for (int i = 0; i < 81; i++) puz[i] = sol[i];
    sol[42] = 5;
    puz[42] = 3;
    puz[65] = 0;
    run_check("wrong46", 0, 1);
    check("wrong46_spec_first", {First_Row, First_Col}, {4'd4, 4'd6});

    for (int i = 0; i < 81; i++) puz[i] = sol[i];
    puz[80] = 15;
    run_check("last15", 0, 1);
    check("last15_spec_first", {First_Valid, First_Row, First_Col}, {1'b1, 4'd8, 4'd8});

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 81; i++) begin
        r = $urandom_range(0, 99);
        if (r < 60)      puz[i] = sol[i];
        else if (r < 78) puz[i] = 0;
        else             puz[i] = $urandom_range(1, 15);
      end
      run_check($sformatf("rand%0d", t), (t == 1), 1);
    end

    // Reset in the 40th scan cycle with a grid that has already produced results
    for (int i = 0; i < 81; i++) puz[i] = (i < 30) ? 0 : sol[i];
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (39) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("midrst_rdreq", Rd_Req, 0);
    check("midrst_idle", q_Idle, 1);
    check("midrst_empty", Empty_Count, 0);
    check("midrst_first_valid", First_Valid, 0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 81; i++) puz[i] = sol[i];
    run_check("after_rst", 0, 0);

    // Start and Ack together in DONE: Ack wins, no new scan
    addr_log.delete();
    @(negedge Clk);
    Start = 1'b1;
    Ack   = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Ack   = 1'b0;
    check("startack_idle", q_Idle, 1);
    repeat (3) @(posedge Clk);
    #1;
    check("startack_still_idle", q_Idle, 1);
    check("startack_no_reads", addr_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
